// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, counter types and the colour-bar lookup.
// Pure definitions; no latency, no flow control.
package vga_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int CLK_DIV = 4;

  localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int BAR_WIDTH    = 80;

  localparam int CNT_W = 10;
  localparam int DIV_W = 2;

  typedef struct packed {
    logic red;
    logic green;
    logic blue;
  } rgb_t;

  // Bar 0 (left) is white, counting down the 3-bit colour to black at bar 7.
  function automatic rgb_t bar_colour(input logic [CNT_W-1:0] hcount);
    return rgb_t'(3'd7 - 3'(hcount / CNT_W'(BAR_WIDTH)));
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider plus horizontal/vertical raster counters with raw sync and visible flags.
// Flags are combinational from the counters; free-running, no backpressure.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP,
  parameter int CLK_DIV = vga_pkg::CLK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             visible,
  output logic             hsync_n,
  output logic             vsync_n
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS_N  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_N  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] H_SS     = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] H_SE     = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS     = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] V_SE     = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             pix_tick;

  assign pix_tick = (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div    <= '0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      div <= pix_tick ? '0 : div + 1'b1;
      if (pix_tick) begin
        // The line wrap and the line advance share the same tick.
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end else begin
          hcount <= hcount + 1'b1;
        end
      end
    end
  end

  assign visible = (hcount < H_VIS_N) && (vcount < V_VIS_N);
  assign hsync_n = !((hcount >= H_SS) && (hcount < H_SE));
  assign vsync_n = !((vcount >= V_SS) && (vcount < V_SE));

endmodule

// File: rtl/vga_controller.sv
// VGA 640x480 controller painting an 8-bar colour test pattern with active-low syncs.
// Outputs registered: one clk behind the raster counters; free-running, no backpressure.
module vga_controller
  import vga_pkg::*;
#(
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP,
  parameter int CLK_DIV = vga_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic vga_red,
  output logic vga_green,
  output logic vga_blue,
  output logic vga_hsync,
  output logic vga_vsync
);

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             visible;
  logic             hsync_n;
  logic             vsync_n;
  rgb_t             pixel;
  logic             vcount_unused;

  vga_timing #(
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .CLK_DIV (CLK_DIV)
  ) u_timing (
    .clk     (clk),
    .reset   (reset),
    .hcount  (hcount),
    .vcount  (vcount),
    .visible (visible),
    .hsync_n (hsync_n),
    .vsync_n (vsync_n)
  );

  // The pattern is purely horizontal; the line number only matters through visible.
  assign vcount_unused = ^vcount;

  assign pixel = visible ? bar_colour(hcount) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {vga_red, vga_green, vga_blue} <= 3'b000;
      vga_hsync                      <= 1'b1;
      vga_vsync                      <= 1'b1;
    end else begin
      {vga_red, vga_green, vga_blue} <= pixel;
      vga_hsync                      <= hsync_n;
      vga_vsync                      <= vsync_n;
    end
  end

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: full horizontal timing, vertical timing shrunk to 9 lines/frame.
// Expected samples are queued with their clk-edge index and compared when that edge arrives.
module tb_vga_controller;

  localparam int TV_VIS    = 4;
  localparam int TV_FP     = 1;
  localparam int TV_SYNC   = 2;
  localparam int TV_BP     = 2;
  localparam int TV_TOTAL  = TV_VIS + TV_FP + TV_SYNC + TV_BP;
  localparam int LINE_CLK  = 3200;
  localparam int FRAME_CLK = LINE_CLK * TV_TOTAL;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vga_red, vga_green, vga_blue, vga_hsync, vga_vsync;
  logic [4:0] out;

  vga_controller #(
    .V_VIS  (TV_VIS),
    .V_FP   (TV_FP),
    .V_SYNC (TV_SYNC),
    .V_BP   (TV_BP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vga_red   (vga_red),
    .vga_green (vga_green),
    .vga_blue  (vga_blue),
    .vga_hsync (vga_hsync),
    .vga_vsync (vga_vsync)
  );

  always #5 clk = ~clk;

  assign out = {vga_red, vga_green, vga_blue, vga_hsync, vga_vsync};

  // Rising clk edges since reset release; outputs after edge e show counter time e-1.
  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  int hs_falls[$], hs_rises[$], vs_falls[$], vs_rises[$];
  logic prev_hs = 1'b1;
  logic prev_vs = 1'b1;
  always @(negedge clk) begin
    if (prev_hs && !vga_hsync) hs_falls.push_back(cyc);
    if (!prev_hs && vga_hsync) hs_rises.push_back(cyc);
    if (prev_vs && !vga_vsync) vs_falls.push_back(cyc);
    if (!prev_vs && vga_vsync) vs_rises.push_back(cyc);
    prev_hs = vga_hsync;
    prev_vs = vga_vsync;
  end

  typedef struct {
    int         e;
    logic [4:0] val;
  } exp_t;
  exp_t sb[$];

  logic [2:0] bars [8] = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000};

  function automatic logic [4:0] model(input int e);
    int t, px, ln;
    logic vis, hs, vs;
    logic [2:0] rgb;
    t   = e - 1;
    px  = (t / 4) % 800;
    ln  = (t / LINE_CLK) % TV_TOTAL;
    vis = (px < 640) && (ln < TV_VIS);
    rgb = vis ? 3'(7 - px / 80) : 3'd0;
    hs  = !((px >= 656) && (px < 752));
    vs  = !((ln >= TV_VIS + TV_FP) && (ln < TV_VIS + TV_FP + TV_SYNC));
    return {rgb, hs, vs};
  endfunction

  task automatic push(input int e, input logic [4:0] v);
    exp_t it;
    it.e   = e;
    it.val = v;
    sb.push_back(it);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    exp_t it;
    #1 reset = 1'b0;
    repeat (100) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (out !== 5'b000_11) begin
        n_fail++;
        $display("FAIL reset_hold: out=%b expected 00011", out);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 4; e++) push(e, 5'b111_11);
    push(5, model(5));
    while (sb.size() > 0) begin
      it = sb.pop_front();
      wait_edge(it.e);
      n_checks++;
      if (cyc != it.e || out !== it.val) begin
        n_fail++;
        $display("FAIL first_pixel: edge %0d out=%b expected %b at edge %0d", cyc, out, it.val, it.e);
      end
    end
  endtask

  task automatic test_colour_bars(input int line);
    exp_t it;
    int base;
    base = line * LINE_CLK;
    for (int i = 0; i < 8; i++) push(base + 4 * (40 + 80 * i) + 2, {bars[i], 2'b11});
    for (int p = 640; p < 800; p += 8) push(base + 4 * p + 2, model(base + 4 * p + 2));
    push(base + 4 * 799 + 2, model(base + 4 * 799 + 2));
    while (sb.size() > 0) begin
      it = sb.pop_front();
      wait_edge(it.e);
      n_checks++;
      if (cyc != it.e || out !== it.val) begin
        n_fail++;
        $display("FAIL bars_line%0d: edge %0d out=%b expected %b at edge %0d", line, cyc, out, it.val, it.e);
      end
    end
  endtask

  task automatic test_line_timing;
    wait_edge(3 * LINE_CLK - 100);
    n_checks++;
    if (hs_falls.size() < 3 || hs_rises.size() < 1) begin
      n_fail++;
      $display("FAIL hsync_edges: falls=%0d rises=%0d expected >=3 and >=1", hs_falls.size(), hs_rises.size());
    end else begin
      n_checks++;
      if (hs_falls[0] != 656 * 4 + 1) begin
        n_fail++;
        $display("FAIL hsync_offset: %0d expected %0d", hs_falls[0], 656 * 4 + 1);
      end
      n_checks++;
      if (hs_rises[0] - hs_falls[0] != 384) begin
        n_fail++;
        $display("FAIL hsync_width: %0d expected 384", hs_rises[0] - hs_falls[0]);
      end
      n_checks++;
      if (hs_falls[1] - hs_falls[0] != LINE_CLK || hs_falls[2] - hs_falls[1] != LINE_CLK) begin
        n_fail++;
        $display("FAIL hsync_period: %0d,%0d expected %0d", hs_falls[1] - hs_falls[0],
                 hs_falls[2] - hs_falls[1], LINE_CLK);
      end
    end
  endtask

  task automatic test_blanking;
    int bad = 0;
    wait_edge(TV_VIS * LINE_CLK);
    hs_falls.delete();
    hs_rises.delete();
    for (int e = TV_VIS * LINE_CLK + 1; e <= FRAME_CLK; e++) begin
      wait_edge(e);
      n_checks++;
      if (out[4:2] !== 3'b000) begin
        n_fail++;
        if (bad < 5) $display("FAIL blank_rgb: edge %0d rgb=%b expected 000", cyc, out[4:2]);
        bad++;
      end
    end
    n_checks++;
    if (hs_falls.size() != TV_TOTAL - TV_VIS || hs_rises.size() != TV_TOTAL - TV_VIS) begin
      n_fail++;
      $display("FAIL blank_hsync: falls=%0d rises=%0d expected %0d", hs_falls.size(),
               hs_rises.size(), TV_TOTAL - TV_VIS);
    end
  endtask

  task automatic test_frame_timing;
    wait_edge(FRAME_CLK + (TV_VIS + TV_FP) * LINE_CLK + 10);
    n_checks++;
    if (vs_falls.size() < 2 || vs_rises.size() < 1) begin
      n_fail++;
      $display("FAIL vsync_edges: falls=%0d rises=%0d expected >=2 and >=1", vs_falls.size(), vs_rises.size());
    end else begin
      n_checks++;
      if (vs_falls[0] != (TV_VIS + TV_FP) * LINE_CLK + 1) begin
        n_fail++;
        $display("FAIL vsync_offset: %0d expected %0d", vs_falls[0], (TV_VIS + TV_FP) * LINE_CLK + 1);
      end
      n_checks++;
      if (vs_rises[0] - vs_falls[0] != 6400) begin
        n_fail++;
        $display("FAIL vsync_width: %0d expected 6400", vs_rises[0] - vs_falls[0]);
      end
      n_checks++;
      if (vs_falls[1] - vs_falls[0] != FRAME_CLK) begin
        n_fail++;
        $display("FAIL vsync_period: %0d expected %0d", vs_falls[1] - vs_falls[0], FRAME_CLK);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    exp_t it;
    int e0;
    e0 = 2 * FRAME_CLK + 2 * LINE_CLK + 300 * 4 + 2;
    push(e0, model(e0));
    it = sb.pop_front();
    wait_edge(it.e);
    n_checks++;
    if (cyc != it.e || out !== it.val) begin
      n_fail++;
      $display("FAIL pre_reset_pixel: edge %0d out=%b expected %b", cyc, out, it.val);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (out !== 5'b000_11) begin
      n_fail++;
      $display("FAIL async_reset: out=%b expected 00011", out);
    end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    vs_falls.delete();
    push(1, 5'b111_11);
    push(4, 5'b111_11);
    push(LINE_CLK + 4 * 280 + 2, {3'b100, 2'b11});
    while (sb.size() > 0) begin
      it = sb.pop_front();
      wait_edge(it.e);
      n_checks++;
      if (cyc != it.e || out !== it.val) begin
        n_fail++;
        $display("FAIL restart: edge %0d out=%b expected %b at edge %0d", cyc, out, it.val, it.e);
      end
    end
    wait_edge((TV_VIS + TV_FP) * LINE_CLK + 10);
    n_checks++;
    if (vs_falls.size() != 1 || vs_falls[0] != (TV_VIS + TV_FP) * LINE_CLK + 1) begin
      n_fail++;
      $display("FAIL restart_vsync: falls=%0d first=%0d expected 1 at %0d", vs_falls.size(),
               (vs_falls.size() > 0) ? vs_falls[0] : -1, (TV_VIS + TV_FP) * LINE_CLK + 1);
    end
  endtask

  initial begin
    test_reset();
    test_colour_bars(0);
    test_line_timing();
    test_colour_bars(3);
    test_blanking();
    test_frame_timing();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
